// File: rtl/fetch_mem_unit_if.sv
// fetch_mem_unit_if: unified memory port bundle.
// Master side is the fetch/mem stage, slave is memory.
interface fetch_mem_unit_if;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic        mem_ready;

  modport master (
    output mem_req,
    output mem_we,
    output mem_addr,
    output mem_wdata,
    input  mem_rdata,
    input  mem_ready
  );

  modport slave (
    input  mem_req,
    input  mem_we,
    input  mem_addr,
    input  mem_wdata,
    output mem_rdata,
    output mem_ready
  );
endinterface

// File: rtl/fetch_mem_unit.sv
// fetch_mem_unit: PC/IR/MDR owner and memory handshake.
// Optional FETCH_MEM_PERF_EN adds instret/stall_cycles.
module fetch_mem_unit #(
  parameter int                ADDR_W   = 32,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              PC_Update,
  input  logic              Branch,
  input  logic              Zero,
  input  logic              AdrSrc,
  input  logic              Mem_Write,
  input  logic              IR_Write,
  input  logic [ADDR_W-1:0] Result,
  input  logic [ADDR_W-1:0] Write_Data,
  fetch_mem_unit_if.master  mem,
  output logic [ADDR_W-1:0] PC,
  output logic [ADDR_W-1:0] Old_PC,
  output logic [ADDR_W-1:0] Instr,
  output logic [6:0]        Op,
  output logic [ADDR_W-1:0] Data,
  output logic              Stall
`ifdef FETCH_MEM_PERF_EN
  ,
  output logic [31:0]       instret,
  output logic [31:0]       stall_cycles
`endif
);

  typedef enum logic {
    S_IDLE,
    S_WAIT
  } state_t;

  typedef enum logic [1:0] {
    K_NONE,
    K_FETCH,
    K_READ,
    K_WRITE
  } kind_t;

  state_t            state;
  kind_t             lat_kind;
  logic [ADDR_W-1:0] lat_addr;
  logic [ADDR_W-1:0] lat_wdata;

  logic              acc;
  kind_t             kind_in;
  kind_t             kind_c;
  logic              req_c;
  logic [ADDR_W-1:0] addr_c;
  logic [ADDR_W-1:0] wdata_c;
  logic [ADDR_W-1:0] sel_addr;
  logic              done;
  logic              pc_we;

  assign acc      = IR_Write | AdrSrc;
  assign sel_addr = AdrSrc ? Result : PC;

  // Classify the live request; AdrSrc overrides IR_Write.
  always_comb begin
    kind_in = K_NONE;
    unique case (1'b1)
      AdrSrc & Mem_Write:  kind_in = K_WRITE;
      AdrSrc & !Mem_Write: kind_in = K_READ;
      IR_Write & !AdrSrc:  kind_in = K_FETCH;
      default:             kind_in = K_NONE;
    endcase
  end

  // Port drive: live request in IDLE, frozen copy in WAIT.
  always_comb begin
    req_c   = 1'b0;
    addr_c  = '0;
    wdata_c = '0;
    kind_c  = K_NONE;
    if (state == S_IDLE) begin
      req_c   = acc;
      addr_c  = {sel_addr[ADDR_W-1:2], 2'b00};
      wdata_c = Write_Data;
      kind_c  = kind_in;
    end else begin
      req_c   = 1'b1;
      addr_c  = lat_addr;
      wdata_c = lat_wdata;
      kind_c  = lat_kind;
    end
  end

  assign mem.mem_req   = reset & req_c;
  assign mem.mem_we    = (kind_c == K_WRITE);
  assign mem.mem_addr  = addr_c;
  assign mem.mem_wdata = wdata_c;

  assign Stall = reset & req_c & !mem.mem_ready;
  assign done  = reset & req_c & mem.mem_ready;
  assign pc_we = (PC_Update | (Branch & Zero)) & !Stall;
  assign Op    = Instr[6:0];

  // Handshake FSM; latches the access when memory stalls.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= S_IDLE;
      lat_kind  <= K_NONE;
      lat_addr  <= '0;
      lat_wdata <= '0;
    end else begin
      unique case (state)
        S_IDLE: begin
          if (req_c && !mem.mem_ready) begin
            state     <= S_WAIT;
            lat_kind  <= kind_c;
            lat_addr  <= addr_c;
            lat_wdata <= wdata_c;
          end
        end
        S_WAIT: begin
          if (mem.mem_ready) begin
            state <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // Architectural registers updated on completion/PC write.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      PC     <= RESET_PC;
      Old_PC <= '0;
      Instr  <= '0;
      Data   <= '0;
    end else begin
      if (done && kind_c == K_FETCH) begin
        Instr  <= mem.mem_rdata;
        Old_PC <= PC;
      end
      if (done && kind_c == K_READ) begin
        Data <= mem.mem_rdata;
      end
      if (pc_we) begin
        PC <= Result;
      end
    end
  end

`ifdef FETCH_MEM_PERF_EN
  // Retired-fetch and stall-cycle counters, free-wrapping.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      instret      <= '0;
      stall_cycles <= '0;
    end else begin
      if (done && kind_c == K_FETCH) begin
        instret <= instret + 32'd1;
      end
      if (Stall) begin
        stall_cycles <= stall_cycles + 32'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_fetch_mem_unit.sv
// tb_fetch_mem_unit: vector table plus register scoreboard.
// Hand sequence covers reset during an outstanding access.
module tb_fetch_mem_unit;

  logic        clk;
  logic        reset;
  logic        PC_Update, Branch, Zero;
  logic        AdrSrc, Mem_Write, IR_Write;
  logic [31:0] Result, Write_Data;
  logic [31:0] PC, Old_PC, Instr, Data;
  logic [6:0]  Op;
  logic        Stall;
`ifdef FETCH_MEM_PERF_EN
  logic [31:0] instret, stall_cycles;
`endif

  fetch_mem_unit_if bus ();

  fetch_mem_unit #(
    .ADDR_W  (32),
    .RESET_PC(32'h0)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .PC_Update (PC_Update),
    .Branch    (Branch),
    .Zero      (Zero),
    .AdrSrc    (AdrSrc),
    .Mem_Write (Mem_Write),
    .IR_Write  (IR_Write),
    .Result    (Result),
    .Write_Data(Write_Data),
    .mem       (bus.master),
    .PC        (PC),
    .Old_PC    (Old_PC),
    .Instr     (Instr),
    .Op        (Op),
    .Data      (Data),
    .Stall     (Stall)
`ifdef FETCH_MEM_PERF_EN
    ,
    .instret     (instret),
    .stall_cycles(stall_cycles)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic        pcu, br, z, adr, mw, irw;
    logic [31:0] res, wd, rd;
    logic        rdy;
    logic        ereq, ewe, estall;
    logic [31:0] eaddr, ewd;
    logic [31:0] epc, eir, eold, edata;
  } vec_t;

  typedef struct {
    string       name;
    logic [31:0] pc, ir, old, data;
  } post_t;

  vec_t  vecs[$];
  post_t sb[$];
  int    vectors;
  int    miscompares;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  function automatic vec_t mk(
    input string nm,
    input logic pcu, br, z, adr, mw, irw,
    input logic [31:0] res, wd, rd,
    input logic rdy,
    input logic ereq, ewe, estall,
    input logic [31:0] eaddr, ewd,
    input logic [31:0] epc, eir, eold, edata);
    vec_t v;
    v.name = nm;
    v.pcu = pcu; v.br = br; v.z = z;
    v.adr = adr; v.mw = mw; v.irw = irw;
    v.res = res; v.wd = wd; v.rd = rd; v.rdy = rdy;
    v.ereq = ereq; v.ewe = ewe; v.estall = estall;
    v.eaddr = eaddr; v.ewd = ewd;
    v.epc = epc; v.eir = eir; v.eold = eold; v.edata = edata;
    return v;
  endfunction

  task automatic idle_inputs();
    PC_Update = 0; Branch = 0; Zero = 0;
    AdrSrc = 0; Mem_Write = 0; IR_Write = 0;
    Result = 0; Write_Data = 0;
    bus.mem_ready = 0; bus.mem_rdata = 0;
  endtask

  initial begin
    vectors = 0;
    miscompares = 0;
    idle_inputs();
    reset = 1'b0;

    // name pcu br z adr mw irw res wd rd rdy
    // ereq ewe estall eaddr ewd pc ir old data
    vecs.push_back(mk("fetch0", 1,0,0,0,0,1,
      32'h4, 32'h0, 32'h00500093, 1,
      1,0,0, 32'h0, 32'h0,
      32'h4, 32'h00500093, 32'h0, 32'h0));
    vecs.push_back(mk("fetchw1", 1,0,0,0,0,1,
      32'h8, 32'h0, 32'hFFFFFFFF, 0,
      1,0,1, 32'h4, 32'h0,
      32'h4, 32'h00500093, 32'h0, 32'h0));
    vecs.push_back(mk("fetchw2", 1,0,0,0,0,1,
      32'hC, 32'h0, 32'hFFFFFFFF, 0,
      1,0,1, 32'h4, 32'h0,
      32'h4, 32'h00500093, 32'h0, 32'h0));
    vecs.push_back(mk("fetchw3", 1,0,0,0,0,1,
      32'hC, 32'h0, 32'hFFFFFFFF, 0,
      1,0,1, 32'h4, 32'h0,
      32'h4, 32'h00500093, 32'h0, 32'h0));
    vecs.push_back(mk("fetchw_done", 1,0,0,0,0,1,
      32'hC, 32'h0, 32'h00002183, 1,
      1,0,0, 32'h4, 32'h0,
      32'hC, 32'h00002183, 32'h4, 32'h0));
    vecs.push_back(mk("store_w", 0,0,0,1,1,0,
      32'h103, 32'hDEADBEEF, 32'h0, 0,
      1,1,1, 32'h100, 32'hDEADBEEF,
      32'hC, 32'h00002183, 32'h4, 32'h0));
    vecs.push_back(mk("store_done", 0,0,0,1,0,0,
      32'h555, 32'h11111111, 32'h77777777, 1,
      1,1,0, 32'h100, 32'hDEADBEEF,
      32'hC, 32'h00002183, 32'h4, 32'h0));
    vecs.push_back(mk("load", 0,0,0,1,0,0,
      32'h200, 32'h0, 32'h12345678, 1,
      1,0,0, 32'h200, 32'h0,
      32'hC, 32'h00002183, 32'h4, 32'h12345678));
    vecs.push_back(mk("br_nz", 0,1,0,0,0,0,
      32'h40, 32'h0, 32'h0, 0,
      0,0,0, 32'hC, 32'h0,
      32'hC, 32'h00002183, 32'h4, 32'h12345678));
    vecs.push_back(mk("br_z", 0,1,1,0,0,0,
      32'h40, 32'h0, 32'h0, 0,
      0,0,0, 32'hC, 32'h0,
      32'h40, 32'h00002183, 32'h4, 32'h12345678));
    vecs.push_back(mk("br_stall1", 0,1,1,1,0,0,
      32'h300, 32'h0, 32'h0, 0,
      1,0,1, 32'h300, 32'h0,
      32'h40, 32'h00002183, 32'h4, 32'h12345678));
    vecs.push_back(mk("br_stall2", 0,1,1,1,0,0,
      32'h300, 32'h0, 32'h0, 0,
      1,0,1, 32'h300, 32'h0,
      32'h40, 32'h00002183, 32'h4, 32'h12345678));
    vecs.push_back(mk("load_done", 0,0,0,1,0,0,
      32'h300, 32'h0, 32'hCAFEF00D, 1,
      1,0,0, 32'h300, 32'h0,
      32'h40, 32'h00002183, 32'h4, 32'hCAFEF00D));
    vecs.push_back(mk("ready_idle", 0,0,0,0,0,0,
      32'h0, 32'h0, 32'hFFFFFFFF, 1,
      0,0,0, 32'h40, 32'h0,
      32'h40, 32'h00002183, 32'h4, 32'hCAFEF00D));
    vecs.push_back(mk("both_req", 0,0,0,1,0,1,
      32'h404, 32'h0, 32'hABCD0000, 1,
      1,0,0, 32'h404, 32'h0,
      32'h40, 32'h00002183, 32'h4, 32'hABCD0000));
    vecs.push_back(mk("mw_on_fetch", 1,0,0,0,1,1,
      32'h44, 32'h0, 32'h00000063, 1,
      1,0,0, 32'h40, 32'h0,
      32'h44, 32'h00000063, 32'h40, 32'hABCD0000));

    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_req", {31'b0, bus.mem_req}, 32'h0);
    chk("rst_stall", {31'b0, Stall}, 32'h0);
    chk("rst_pc", PC, 32'h0);
    chk("rst_instr", Instr, 32'h0);
    chk("rst_oldpc", Old_PC, 32'h0);
    chk("rst_data", Data, 32'h0);
    reset = 1'b1;
    @(posedge clk);
    #1;

    foreach (vecs[i]) begin
      vec_t  v;
      post_t p;
      post_t e;
      v = vecs[i];
      PC_Update = v.pcu; Branch = v.br; Zero = v.z;
      AdrSrc = v.adr; Mem_Write = v.mw; IR_Write = v.irw;
      Result = v.res; Write_Data = v.wd;
      bus.mem_rdata = v.rd; bus.mem_ready = v.rdy;
      @(negedge clk);
      chk({v.name, ".req"}, {31'b0, bus.mem_req}, {31'b0, v.ereq});
      chk({v.name, ".stall"}, {31'b0, Stall}, {31'b0, v.estall});
      chk({v.name, ".addr"}, bus.mem_addr, v.eaddr);
      if (v.ereq) chk({v.name, ".we"}, {31'b0, bus.mem_we}, {31'b0, v.ewe});
      if (v.ewe) chk({v.name, ".wdata"}, bus.mem_wdata, v.ewd);
      p.name = v.name;
      p.pc = v.epc; p.ir = v.eir; p.old = v.eold; p.data = v.edata;
      sb.push_back(p);
      @(posedge clk);
      #1;
      e = sb.pop_front();
      chk({e.name, ".pc"}, PC, e.pc);
      chk({e.name, ".instr"}, Instr, e.ir);
      chk({e.name, ".oldpc"}, Old_PC, e.old);
      chk({e.name, ".data"}, Data, e.data);
      chk({e.name, ".op"}, {25'b0, Op}, {25'b0, e.ir[6:0]});
    end

    // Reset while a fetch is waiting on memory.
    idle_inputs();
    PC_Update = 1; IR_Write = 1; Result = 32'h48;
    @(negedge clk);
    chk("rw.stall_pre", {31'b0, Stall}, 32'h1);
    @(posedge clk);
    #2;
    reset = 1'b0;
    #1;
    chk("rw.req", {31'b0, bus.mem_req}, 32'h0);
    chk("rw.stall", {31'b0, Stall}, 32'h0);
    chk("rw.pc", PC, 32'h0);
    chk("rw.instr", Instr, 32'h0);
`ifdef FETCH_MEM_PERF_EN
    chk("rw.instret", instret, 32'h0);
    chk("rw.stall_cycles", stall_cycles, 32'h0);
`endif
    idle_inputs();
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;
    bus.mem_ready = 1; bus.mem_rdata = 32'hFFFFFFFF;
    @(posedge clk);
    #1;
    bus.mem_ready = 0;
    chk("rw.instr_after", Instr, 32'h0);
    chk("rw.pc_after", PC, 32'h0);

    // Two back-to-back zero-wait fetches.
    PC_Update = 1; IR_Write = 1; Result = 32'h4;
    bus.mem_ready = 1; bus.mem_rdata = 32'h00000013;
    @(posedge clk);
    #1;
    Result = 32'h8; bus.mem_rdata = 32'h00000033;
    @(posedge clk);
    #1;
    idle_inputs();
    chk("b2b.pc", PC, 32'h8);
    chk("b2b.oldpc", Old_PC, 32'h4);
    chk("b2b.instr", Instr, 32'h00000033);
`ifdef FETCH_MEM_PERF_EN
    chk("b2b.instret", instret, 32'h2);
`endif

    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/fetch_mem_unit.md
Name: fetch_mem_unit

Overview:
- Datapath stage directly downstream of the multicycle control FSM.
- Consumes PC_Update, Branch, AdrSrc, Mem_Write and IR_Write, and owns PC, OldPC, the instruction register (IR) and the memory data register (MDR).
- Arbitrates the single unified memory port with a req/ready handshake, and produces Op back to the control FSM.
- Raises Stall while a memory access is outstanding; the control FSM holds its state while Stall=1.

Parameters:
RESET_PC, 32'h0000_0000, PC value loaded at reset
ADDR_W, 32, address and data width (fixed at 32 for RV32I)

Ports:
clk  in  1  system clock, rising edge
reset  in  1  asynchronous, active-low reset
PC_Update  in  1  unconditional PC write request from the control FSM
Branch  in  1  conditional PC write request (BEQ)
Zero  in  1  ALU zero flag
AdrSrc  in  1  memory address select: 0=PC, 1=Result
Mem_Write  in  1  data store request (valid only with AdrSrc=1)
IR_Write  in  1  instruction fetch request (valid only with AdrSrc=0)
Result  in  32  result-mux value; next PC and data address
Write_Data  in  32  store data (rs2 register value)
mem_rdata  in  32  memory read data, valid when mem_ready=1
mem_ready  in  1  memory completes the current request this cycle
mem_req  out  1  memory request valid
mem_we  out  1  1=write, 0=read
mem_addr  out  32  word address, bits [1:0] forced to 0
mem_wdata  out  32  store data
PC  out  32  program counter
Old_PC  out  32  PC of the instruction held in Instr
Instr  out  32  instruction register
Op  out  7  Instr[6:0]
Data  out  32  memory data register
Stall  out  1  access outstanding; control FSM must freeze

Behaviour:
- Reset (async, reset=0):
  - PC=RESET_PC; Old_PC, Instr and Data = 0.
  - Handshake FSM goes to IDLE; mem_req=0, Stall=0.
  - Asserting reset mid-access drops mem_req immediately. A mem_ready arriving after release is ignored.
- Access request: acc = IR_Write | AdrSrc. Writes are decided by we = AdrSrc & Mem_Write.
- Handshake FSM has two states, IDLE and WAIT.
- IDLE:
  - mem_req = acc.
  - mem_addr = (AdrSrc ? Result : PC) & ~3.
  - mem_we = we; mem_wdata = Write_Data (combinational).
  - On acc & mem_ready: the access completes this cycle, Stall=0, and the FSM stays in IDLE (zero wait states).
  - On acc & !mem_ready: Stall=1. Latch addr, we, wdata and kind (fetch/read/write), then go to WAIT.
- WAIT:
  - mem_req=1; the latched addr, we and wdata drive the port and stay stable regardless of input changes.
  - Stall = !mem_ready.
  - On mem_ready: complete and return to IDLE.
  - Next-cycle back-to-back requests are issued from IDLE.
- Completion effects, registered at the completing edge:
  - Fetch: Instr<=mem_rdata, Old_PC<=PC.
  - Data read: Data<=mem_rdata.
  - Write: no register update.
- mem_ready while mem_req=0 is ignored.
- PC write:
  - pc_we = (PC_Update | (Branch & Zero)) & !Stall; on pc_we, PC<=Result.
  - In the fetch cycle (PC_Update=1 with IR_Write=1), PC updates only in the completing cycle, together with the Instr capture. Old_PC therefore gets the pre-increment PC.
- Simultaneous IR_Write and AdrSrc=1 is illegal. AdrSrc wins and the access is treated as data; IR_Write is ignored.
- Mem_Write with AdrSrc=0 is illegal and is ignored (read/fetch).
- Op = Instr[6:0], combinational.

Optional Feature:
FETCH_MEM_PERF_EN
- Defined:
  - Adds outputs instret (32), incremented on every fetch completion, and stall_cycles (32), incremented on every cycle with Stall=1.
  - Both reset to 0 and wrap at 2^32.
- Undefined: these ports and counters do not exist; all other behaviour is identical.

Test Plan:
- Reset with RESET_PC=0, then IR_Write=1, PC_Update=1, Result=4, mem_ready=1, mem_rdata=32'h00500093:
  - same cycle: mem_req=1, mem_addr=0, Stall=0
  - next cycle: Instr=32'h00500093, Op=7'h13, Old_PC=0, PC=4
- Fetch with mem_ready held low for 3 cycles:
  - Stall=1 for exactly 3 cycles; mem_addr stays 4 even though Result changes to 8
  - PC, Instr and Old_PC are updated only on the ready cycle
- Store with AdrSrc=1, Mem_Write=1, Result=32'h103, Write_Data=32'hDEADBEEF, ready after 1 wait:
  - mem_we=1, mem_addr=32'h100, mem_wdata=32'hDEADBEEF held through WAIT
  - Data is unchanged
- Load with AdrSrc=1, Mem_Write=0, Result=32'h200, mem_rdata=32'h12345678, mem_ready=1:
  - next cycle Data=32'h12345678; PC and Instr are unchanged
- Branch=1 with Zero=0, then Zero=1, Result=32'h40:
  - PC is unchanged first, then becomes 32'h40
  - Repeat with Stall=1: PC stays unchanged
- reset asserted in WAIT, then mem_ready pulsed after release:
  - immediately mem_req=0, Stall=0, PC=RESET_PC
  - Instr remains 0 after the ready pulse
  - With FETCH_MEM_PERF_EN, instret=0 after the first two completed fetches' predecessor reset, then 2 after two fetches.
